// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM states
// and byte-lane enable masks.
package mem_pkg;

  // Access width field. For stores, WIDTH_BYTEU is the reserved encoding.
  typedef enum logic [1:0] {
    WIDTH_WORD  = 2'b00,
    WIDTH_HALF  = 2'b01,
    WIDTH_BYTE  = 2'b10,
    WIDTH_BYTEU = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte-lane enables, lane k = bits 8k+7:8k (little-endian).
  localparam logic [3:0] LANES_NONE    = 4'b0000;
  localparam logic [3:0] LANES_ALL     = 4'b1111;
  localparam logic [3:0] LANES_HALF_LO = 4'b0011;
  localparam logic [3:0] LANES_HALF_HI = 4'b1100;
  localparam logic [3:0] LANES_BYTE0   = 4'b0001;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory.
// Store path: builds lane enables and a lane-replicated write word.
// Load path: extracts the addressed half/byte and sign- or zero-extends it.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  w_width,
  input  logic [31:0] w_data,
  output logic [3:0]  lane_en,
  output logic [31:0] w_word,
  input  logic [31:0] raw_word,
  input  logic [1:0]  r_width,
  output logic [31:0] r_data
);

  logic [15:0] half_sel;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;

  // Store lane enables and replicated data; reserved width writes nothing.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    lane_en = LANES_NONE;
    w_word  = '0;
    case (width_e'(w_width))
      WIDTH_WORD: begin
        lane_en = LANES_ALL;
        w_word  = w_data;
      end
      WIDTH_HALF: begin
        lane_en = addr_lo[1] ? LANES_HALF_HI : LANES_HALF_LO;
        w_word  = {2{w_data[15:0]}};
      end
      WIDTH_BYTE: begin
        lane_en = LANES_BYTE0 << addr_lo;
        w_word  = {4{w_data[7:0]}};
      end
      default: begin
        lane_en = LANES_NONE;
        w_word  = '0;
      end
    endcase
  end

  // Load extraction: pick the addressed half/byte, then extend per width.
  always_comb begin
    half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    shifted  = raw_word >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    case (width_e'(r_width))
      WIDTH_WORD: r_data = raw_word;
      WIDTH_HALF: r_data = {{16{half_sel[15]}}, half_sel};
      WIDTH_BYTE: r_data = {{24{byte_sel[7]}}, byte_sel};
      default:    r_data = {24'b0, byte_sel};
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the pipeline data-memory interface. Accepts one load or
// store, waits WAIT_STATES cycles, then issues a one-cycle response.
// Optional macro MEM_ALIGN_CHECK_EN: fault misaligned word/half accesses.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        R_Enable,
  input  logic        W_Enable,
  input  logic [1:0]  R_Width,
  input  logic [1:0]  W_Width,
  input  logic [31:0] Address,
  input  logic [31:0] W_Data,
  output logic        Resp_Valid,
  output logic [31:0] R_Data,
  output logic        Resp_Error
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e      state, state_next;
  logic [3:0]  wait_cnt;
  logic        accept, enter_resp;

  logic        lat_re, lat_we;
  logic [1:0]  lat_rw, lat_ww;
  logic [31:0] lat_addr, lat_wdata;

  // Working request: live inputs while idle (only used when WAIT_STATES=0
  // enters RESP on the accept edge), otherwise the latched copy.
  logic        cur_re, cur_we;
  logic [1:0]  cur_rw, cur_ww;
  logic [31:0] cur_addr, cur_wdata;

  logic [IDX_W-1:0] word_idx;
  logic             fault, misaligned;
  logic [3:0]       lane_en;
  logic [31:0]      w_word, raw_word, load_data;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept     = (state == ST_IDLE) && Req_Valid && (R_Enable || W_Enable);
  assign enter_resp = (state_next == ST_RESP);
  assign Req_Ready  = (state == ST_IDLE);
  assign Resp_Valid = (state == ST_RESP);

  assign cur_re    = (state == ST_IDLE) ? R_Enable : lat_re;
  assign cur_we    = (state == ST_IDLE) ? W_Enable : lat_we;
  assign cur_rw    = (state == ST_IDLE) ? R_Width  : lat_rw;
  assign cur_ww    = (state == ST_IDLE) ? W_Width  : lat_ww;
  assign cur_addr  = (state == ST_IDLE) ? Address  : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? W_Data   : lat_wdata;

  assign word_idx = cur_addr[IDX_W+1:2];
  assign raw_word = mem[word_idx];

`ifdef MEM_ALIGN_CHECK_EN
  logic [1:0] acc_width;
  assign acc_width  = cur_re ? cur_rw : cur_ww;
  assign misaligned = ((width_e'(acc_width) == WIDTH_WORD) && (cur_addr[1:0] != 2'b00)) ||
                      ((width_e'(acc_width) == WIDTH_HALF) && cur_addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  assign fault = (cur_re && cur_we) ||
                 ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) ||
                 (cur_we && (width_e'(cur_ww) == WIDTH_BYTEU)) ||
                 misaligned;

  mem_lane_align u_align (
    .addr_lo  (cur_addr[1:0]),
    .w_width  (cur_ww),
    .w_data   (cur_wdata),
    .lane_en  (lane_en),
    .w_word   (w_word),
    .raw_word (raw_word),
    .r_width  (cur_rw),
    .r_data   (load_data)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept in IDLE, count down in BUSY, single-cycle RESP.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (WAIT_STATES == 0) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (wait_cnt == 4'd1) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, decremented while busy.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                                    wait_cnt <= '0;
    else if (accept)                               wait_cnt <= WAIT_INIT;
    else if (state == ST_BUSY && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
  end

  // Request latch captured on accept.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      lat_re    <= 1'b0;
      lat_we    <= 1'b0;
      lat_rw    <= '0;
      lat_ww    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_re    <= R_Enable;
      lat_we    <= W_Enable;
      lat_rw    <= R_Width;
      lat_ww    <= W_Width;
      lat_addr  <= Address;
      lat_wdata <= W_Data;
    end
  end

  // RAM write with byte enables on the edge entering RESP.
  always_ff @(posedge Clock) begin
    // NOTE: the RAM array has no reset; its contents are undefined at power-up
    // and a reset branch would prevent mapping onto memory macros.
    if (enter_resp && Reset && cur_we && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[word_idx][8*k +: 8] <= w_word[8*k +: 8];
      end
    end
  end

  // Response registers: updated entering RESP, held otherwise.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      R_Data     <= '0;
      Resp_Error <= 1'b0;
    end else if (enter_resp) begin
      Resp_Error <= fault;
      R_Data     <= (fault || !cur_re) ? 32'h0 : load_data;
    end
  end

endmodule
